// File: rtl/alpha_u_packer.sv
// ============================================================================
//  Module   : alpha_u_packer
//  Purpose  : Collects alpha (double) and x (symbol index) stream beats into
//             shadow tables and publishes them as one frame pulse.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alpha_u_packer #(
    parameter  int J           = 14,
    parameter  int A           = 2,
    parameter  int HOLD_CYCLES = 9,
    localparam int J_WIDTH     = $clog2(J) + 1,
    localparam int A_WIDTH     = $clog2(A) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [63:0]              s_alpha_tdata,
    input  logic                     s_alpha_tvalid,
    output logic                     s_alpha_tready,
    input  logic                     s_alpha_tlast,
    input  logic [A_WIDTH-1:0]       s_x_tdata,
    input  logic                     s_x_tvalid,
    output logic                     s_x_tready,
    input  logic                     s_x_tlast,
    output logic [J*A*64-1:0]        alpha_u,
    output logic                     alpha_u_tvalid,
    output logic [J*A_WIDTH-1:0]     x_initial,
    output logic                     x_initial_tvalid,
    input  logic                     err_clr,
    output logic                     err_frame,
    output logic                     err_x_range,
    output logic [15:0]              frame_cnt
);

    localparam int NA    = J * A;
    localparam int AC_W  = $clog2(NA) + 1;
    localparam int GAP_W = $clog2(HOLD_CYCLES + 2);

    localparam logic [AC_W-1:0]    c_alpha_full = AC_W'(NA);
    localparam logic [AC_W-1:0]    c_alpha_last = AC_W'(NA - 1);
    localparam logic [J_WIDTH-1:0] c_x_full     = J_WIDTH'(J);
    localparam logic [J_WIDTH-1:0] c_x_last     = J_WIDTH'(J - 1);
    localparam logic [A_WIDTH-1:0] c_a_val      = A_WIDTH'(A);
    localparam logic [GAP_W-1:0]   c_hold       = GAP_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        WAIT_GAP = 2'd1,
        EMIT     = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AC_W-1:0]        r_alpha_cnt;
    logic [AC_W-1:0]        w_alpha_cnt_nxt;
    logic [J_WIDTH-1:0]     r_x_cnt;
    logic [J_WIDTH-1:0]     w_x_cnt_nxt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [NA*64-1:0]       r_alpha_shadow;
    logic [NA*64-1:0]       w_alpha_shadow_nxt;
    logic [NA*64-1:0]       r_alpha_u;
    logic [J*A_WIDTH-1:0]   r_x_shadow;
    logic [J*A_WIDTH-1:0]   w_x_shadow_nxt;
    logic [J*A_WIDTH-1:0]   r_x_initial;
    logic [15:0]            r_frame_cnt;
    logic                   r_err_frame;
    logic                   r_err_x_range;

    logic w_alpha_acc;
    logic w_x_acc;
    logic w_frame_err;
    logic w_x_bad;
    logic w_done_nxt;

    // Readies are gated by rst_n so they read 0 throughout reset and 1 right after.
    assign s_alpha_tready = rst_n && (r_state == FILL) && (r_alpha_cnt < c_alpha_full);
    assign s_x_tready     = rst_n && (r_state == FILL) && (r_x_cnt < c_x_full);

    assign w_alpha_acc = s_alpha_tvalid && s_alpha_tready;
    assign w_x_acc     = s_x_tvalid && s_x_tready;
    assign w_x_bad     = w_x_acc && (s_x_tdata >= c_a_val);
    assign w_frame_err = (w_alpha_acc && (s_alpha_tlast != (r_alpha_cnt == c_alpha_last)))
                      || (w_x_acc && (s_x_tlast != (r_x_cnt == c_x_last)));

    always_comb begin
        w_alpha_shadow_nxt = r_alpha_shadow;
        w_x_shadow_nxt     = r_x_shadow;
        w_alpha_cnt_nxt    = r_alpha_cnt;
        w_x_cnt_nxt        = r_x_cnt;
        if (w_alpha_acc) begin
            w_alpha_shadow_nxt[int'(r_alpha_cnt)*64 +: 64] = s_alpha_tdata;
        end
        if (w_x_acc) begin
            w_x_shadow_nxt[int'(r_x_cnt)*A_WIDTH +: A_WIDTH] = w_x_bad ? '0 : s_x_tdata;
        end
        if (w_frame_err) begin
            w_alpha_cnt_nxt = '0;
            w_x_cnt_nxt     = '0;
        end else begin
            w_alpha_cnt_nxt = r_alpha_cnt + AC_W'(w_alpha_acc);
            w_x_cnt_nxt     = r_x_cnt + J_WIDTH'(w_x_acc);
        end
    end

    // Completion is judged on the post-accept counts so the pulse lands one cycle after the last beat.
    assign w_done_nxt = (w_alpha_cnt_nxt == c_alpha_full) && (w_x_cnt_nxt == c_x_full);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: begin
                if (w_done_nxt) begin
                    w_state_nxt = (r_gap_cnt == '0) ? EMIT : WAIT_GAP;
                end
            end
            WAIT_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT:    w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_alpha_shadow <= w_alpha_shadow_nxt;
        r_x_shadow     <= w_x_shadow_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alpha_cnt   <= '0;
            r_x_cnt       <= '0;
            r_gap_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_alpha_u     <= '0;
            r_x_initial   <= '0;
            r_err_frame   <= 1'b0;
            r_err_x_range <= 1'b0;
        end else begin
            if (r_state == EMIT) begin
                r_alpha_cnt <= '0;
                r_x_cnt     <= '0;
                r_gap_cnt   <= c_hold;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_alpha_cnt <= w_alpha_cnt_nxt;
                r_x_cnt     <= w_x_cnt_nxt;
                if (r_gap_cnt != '0) begin
                    r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                end
            end
            // Published tables are loaded only as EMIT is entered and then held for the consumer.
            if (w_state_nxt == EMIT) begin
                r_alpha_u   <= w_alpha_shadow_nxt;
                r_x_initial <= w_x_shadow_nxt;
            end
            r_err_frame   <= (r_err_frame & ~err_clr) | w_frame_err;
            r_err_x_range <= (r_err_x_range & ~err_clr) | w_x_bad;
        end
    end

    assign alpha_u          = r_alpha_u;
    assign x_initial        = r_x_initial;
    assign alpha_u_tvalid   = rst_n && (r_state == EMIT);
    assign x_initial_tvalid = rst_n && (r_state == EMIT);
    assign err_frame        = r_err_frame;
    assign err_x_range      = r_err_x_range;
    assign frame_cnt        = r_frame_cnt;

endmodule

`default_nettype wire

// File: doc/alpha_u_packer.md
ALPHA_U_PACKER -- requirements
Module: alpha_u_packer

Interface
REQ-001 Parameter J, default 14: number of variables per frame.
REQ-002 Parameter A, default 2: alphabet size, i.e. candidate values per variable.
REQ-003 Parameter HOLD_CYCLES, default 9: minimum number of idle cycles between output pulses.
REQ-004 Derived widths: J_WIDTH = clog2(J)+1 and A_WIDTH = clog2(A)+1.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 s_alpha_tdata  in  64  one IEEE-754 double per beat.
REQ-008 s_alpha_tvalid / s_alpha_tready / s_alpha_tlast  in / out / in  1 each  AXI-stream handshake for alpha beats.
REQ-009 s_x_tdata  in  A_WIDTH  one initial symbol index per beat.
REQ-010 s_x_tvalid / s_x_tready / s_x_tlast  in / out / in  1 each  AXI-stream handshake for x beats.
REQ-011 alpha_u  out  J*A*64  packed alpha table for the backbone-initial stage.
REQ-012 alpha_u_tvalid  out  1  one-cycle frame pulse.
REQ-013 x_initial  out  J*A_WIDTH  packed symbol indices.
REQ-014 x_initial_tvalid  out  1  one-cycle pulse, same cycle as alpha_u_tvalid.
REQ-015 err_clr  in  1  clears the sticky error flags.
REQ-016 err_frame / err_x_range  out  1 each  sticky error flags.
REQ-017 frame_cnt  out  16  count of emitted frames.

Function
REQ-018 Alpha beat k (k = 0..J*A-1) SHALL be stored at shadow bits [k*64 +: 64], i.e. ordered j-major, a-minor.
REQ-019 X beat j (j = 0..J-1) SHALL be stored at shadow bits [j*A_WIDTH +: A_WIDTH].
REQ-020 Alpha and x streams SHALL fill independently, each with its own counter (alpha 0..J*A, x 0..J).
REQ-021 s_alpha_tready SHALL be 1 only in state FILL with alpha_cnt < J*A; s_x_tready likewise with x_cnt < J.
REQ-022 A beat SHALL be accepted only on the cycle where its tvalid and tready are both 1.
REQ-023 The block SHALL have states FILL, WAIT_GAP and EMIT.
REQ-024 FILL SHALL transition to EMIT when both counters are complete and gap_cnt == 0.
REQ-025 FILL SHALL transition to WAIT_GAP when both counters are complete and gap_cnt != 0.
REQ-026 WAIT_GAP SHALL transition to EMIT when gap_cnt reaches 0, with both treadys held at 0 while in WAIT_GAP.
REQ-027 In EMIT, the block SHALL copy the shadow buffers to alpha_u and x_initial, drive both tvalids to 1 for exactly one cycle, load gap_cnt with HOLD_CYCLES, clear both counters, increment frame_cnt, and return to FILL.
REQ-028 Latency: when the final required beat is accepted in cycle N and gap_cnt == 0, the tvalid pulse SHALL occur in cycle N+1.
REQ-029 alpha_u and x_initial SHALL change only in EMIT and SHALL stay stable between pulses, because the downstream stage reads them over multiple cycles.
REQ-030 gap_cnt SHALL decrement by one per cycle while nonzero, so consecutive pulses are separated by at least HOLD_CYCLES low cycles.
REQ-031 An accepted x beat with value >= A SHALL be stored as 0 and SHALL set err_x_range.
REQ-032 Framing error, either stream: tlast = 1 on a beat that is not the stream's last, or tlast = 0 on its last beat.
REQ-033 On a framing error, err_frame SHALL be set and both counters reset to 0, discarding the partial frame with no emit.
REQ-034 The next accepted beats after a framing error SHALL start a new frame.
REQ-035 err_clr SHALL clear both sticky flags; an error event in the same cycle SHALL take priority and leave its flag set.
REQ-036 frame_cnt SHALL wrap from 0xFFFF to 0.
REQ-037 Simultaneous final beats on both streams in the same cycle SHALL be handled the same as sequential completion.

Reset
REQ-038 While rst_n = 0 (sampled on clk), the block SHALL enter FILL and clear both counters, gap_cnt and frame_cnt.
REQ-039 While rst_n = 0, alpha_u, x_initial, both tvalids and both error flags SHALL be 0, and both treadys SHALL be 0.
REQ-040 A reset asserted mid-frame SHALL discard all accepted beats, and no pulse SHALL follow.
REQ-041 The treadys SHALL return to 1 in the first cycle after rst_n goes high.

Verification
REQ-042 Send 28 alpha beats with k encoded as the double k+1.0 (e.g. 0x3FF0000000000000 for k = 0), plus 14 x beats of alternating 0/1, with correct tlast on both streams -> one pulse, alpha_u[64*k +: 64] = k+1.0 for every k, x_initial = 0b01 pattern, frame_cnt = 1.
REQ-043 Send two back-to-back frames with valid held high -> pulses at least 9 cycles apart, both treadys = 0 during WAIT_GAP, second frame data correct.
REQ-044 Assert alpha tlast on beat 10 -> err_frame = 1 and no pulse; the next clean frame emits correctly; err_clr then clears err_frame to 0.
REQ-045 Send an x beat with value 3 at j = 5 (A = 2) -> x_initial field 5 = 0, err_x_range = 1, and the frame is still emitted.
REQ-046 Assert rst_n = 0 for one cycle after 20 alpha beats -> no pulse; a following full frame emits with frame_cnt = 1.
REQ-047 Run randomized tvalid gaps on both streams over 1000 frames against a scoreboard -> every frame matches, and frame_cnt = 1000 mod 65536.
